// File: rtl/repeat_count_pkg.sv
// Shared types and default widths for the repeat-count scheduler.
package repeat_count_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WORD_W  = 8;
  localparam int DEF_CNT_W   = 10;
  localparam int DEF_SRC_W   = 2;

endpackage

// File: rtl/repeat_count_scheduler_if.sv
// Requester word streams plus the result handshake of the repeat-count scheduler.
interface repeat_count_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 10,
  parameter int SRC_W   = 2
);
  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ*WORD_W-1:0] in_word;
  logic [NUM_REQ-1:0]        in_last;
  logic [NUM_REQ-1:0]        in_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic [CNT_W-1:0]          res_count;
  logic [CNT_W-1:0]          res_len;
  logic [SRC_W-1:0]          res_src;
  logic                      busy;

  modport master (
    output in_valid, in_word, in_last, res_ready,
    input  in_ready, res_valid, res_count, res_len, res_src, busy
  );

  modport slave (
    input  in_valid, in_word, in_last, res_ready,
    output in_ready, res_valid, res_count, res_len, res_src, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index after last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_last_grant,
  output logic [SRC_W-1:0]   o_grant,
  output logic               o_any
);

  int w_idx;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(i_last_grant) + k) % NUM_REQ;
      if (i_req[w_idx]) begin
        o_grant = SRC_W'(w_idx);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/repeat_count_scheduler.sv
// Grants whole bursts round-robin to one shared repeat counter and reports
// {count, length, source} per burst on a valid/ready result port.
module repeat_count_scheduler
  import repeat_count_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int SRC_W   = DEF_SRC_W
) (
  input logic                    clk,
  input logic                    reset_n,
  repeat_count_scheduler_if.slave bus
);

  state_t               r_state, w_state_nxt;
  logic [SRC_W-1:0]     r_grant, r_last_grant, w_arb_grant;
  logic                 w_arb_any;
  logic [CNT_W-1:0]     r_count, r_len, w_count_nxt, w_len_nxt;
  logic [WORD_W-1:0]    r_prev_word, w_word;
  logic                 r_have_prev, w_hs, w_last, w_match;
  logic [NUM_REQ-1:0]   w_ready;
  logic                 r_res_valid;
  logic [CNT_W-1:0]     r_res_count, r_res_len;
  logic [SRC_W-1:0]     r_res_src;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_arb (
    .i_req        (bus.in_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_any        (w_arb_any)
  );

  assign w_word      = bus.in_word[int'(r_grant)*WORD_W +: WORD_W];
  assign w_hs        = (r_state == STREAM) && bus.in_valid[r_grant];
  assign w_last      = bus.in_last[r_grant];
  assign w_match     = r_have_prev && (w_word == r_prev_word);
  assign w_len_nxt   = sat_inc(r_len);
  assign w_count_nxt = w_match ? sat_inc(r_count) : r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    unique case (r_state)
      IDLE:    if (w_arb_any) w_state_nxt = STREAM;
      STREAM: begin
        w_ready[r_grant] = 1'b1;
        if (w_hs && w_last) w_state_nxt = REPORT;
      end
      REPORT:  if (r_res_valid && bus.res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Last-grant starts at the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant      <= '0;
      r_last_grant <= SRC_W'(NUM_REQ-1);
      r_count      <= '0;
      r_len        <= '0;
      r_prev_word  <= '0;
      r_have_prev  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_count  <= '0;
      r_res_len    <= '0;
      r_res_src    <= '0;
    end else begin
      if (r_state == IDLE && w_arb_any) begin
        r_grant      <= w_arb_grant;
        r_last_grant <= w_arb_grant;
        r_count      <= '0;
        r_len        <= '0;
        r_have_prev  <= 1'b0;
      end
      if (w_hs) begin
        r_len       <= w_len_nxt;
        r_count     <= w_count_nxt;
        r_prev_word <= w_word;
        r_have_prev <= 1'b1;
        if (w_last) begin
          r_res_valid <= 1'b1;
          r_res_count <= w_count_nxt;
          r_res_len   <= w_len_nxt;
          r_res_src   <= r_grant;
        end
      end
      if (r_res_valid && bus.res_ready) r_res_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.busy      = (r_state != IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_count = r_res_count;
  assign bus.res_len   = r_res_len;
  assign bus.res_src   = r_res_src;

endmodule

// File: tb/tb_repeat_count_scheduler.sv
// Directed bench for repeat_count_scheduler: default instance plus a CNT_W=4 instance for saturation.
module tb_repeat_count_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] wq [0:31];

  always #5 clk = ~clk;

  repeat_count_scheduler_if #(.NUM_REQ(4), .WORD_W(8), .CNT_W(10), .SRC_W(2)) bus ();
  repeat_count_scheduler_if #(.NUM_REQ(4), .WORD_W(8), .CNT_W(4),  .SRC_W(2)) bus6 ();

  repeat_count_scheduler #(.NUM_REQ(4), .WORD_W(8), .CNT_W(10), .SRC_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  repeat_count_scheduler #(.NUM_REQ(4), .WORD_W(8), .CNT_W(4), .SRC_W(2)) dut6 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives wq[0..n-1] on requester r, waiting (bounded) for in_ready before each word.
  task automatic burst(input int r, input int n);
    int guard;
    bus.in_valid[r] = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.in_word[r*8 +: 8] = wq[i];
      bus.in_last[r]        = (i == n-1);
      guard = 0;
      while (!bus.in_ready[r] && guard < 50) begin
        step();
        guard++;
      end
      check($sformatf("burst_ready_r%0d_w%0d", r, i), 32'(bus.in_ready[r]), 32'd1);
      step();
    end
    bus.in_valid[r] = 1'b0;
    bus.in_last[r]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_src [0:4];
    int nres;
    int guard;

    bus.in_valid = '0;  bus.in_word = '0;  bus.in_last = '0;  bus.res_ready = 1'b1;
    bus6.in_valid = '0; bus6.in_word = '0; bus6.in_last = '0; bus6.res_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_count", 32'(bus.res_count), 32'd0);
    check("rst_res_len",   32'(bus.res_len),   32'd0);
    check("rst_res_src",   32'(bus.res_src),   32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    step();
    reset_n = 1'b1;

    // Test 1: A5,A5,A5,3C,3C -> count 3, len 5, src 0
    wq[0] = 8'hA5; wq[1] = 8'hA5; wq[2] = 8'hA5; wq[3] = 8'h3C; wq[4] = 8'h3C;
    burst(0, 5);
    check("t1_res_valid", 32'(bus.res_valid), 32'd1);
    check("t1_res_count", 32'(bus.res_count), 32'd3);
    check("t1_res_len",   32'(bus.res_len),   32'd5);
    check("t1_res_src",   32'(bus.res_src),   32'd0);
    check("t1_busy",      32'(bus.busy),      32'd1);
    step();
    check("t1_res_valid_clr", 32'(bus.res_valid), 32'd0);
    check("t1_idle",          32'(bus.busy),      32'd0);

    // Test 2: single word 00 on req1 -> count 0, len 1
    wq[0] = 8'h00;
    burst(1, 1);
    check("t2_res_valid", 32'(bus.res_valid), 32'd1);
    check("t2_res_count", 32'(bus.res_count), 32'd0);
    check("t2_res_len",   32'(bus.res_len),   32'd1);
    check("t2_res_src",   32'(bus.res_src),   32'd1);
    step();

    // Test 3: all requesters valid, 1-word bursts, after fresh reset
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    exp_src[0] = 2'd0; exp_src[1] = 2'd1; exp_src[2] = 2'd2; exp_src[3] = 2'd3; exp_src[4] = 2'd0;
    bus.in_valid = 4'hF;
    bus.in_last  = 4'hF;
    bus.in_word  = 32'h44332211;
    nres = 0;
    for (int cyc = 0; cyc < 40 && nres < 5; cyc++) begin
      step();
      check("t3_onehot", 32'($countones(bus.in_ready) <= 1), 32'd1);
      if (bus.res_valid) begin
        check($sformatf("t3_src_%0d", nres), 32'(bus.res_src), 32'(exp_src[nres]));
        check($sformatf("t3_len_%0d", nres), 32'(bus.res_len), 32'd1);
        nres++;
      end
    end
    check("t3_nres", 32'(nres), 32'd5);
    bus.in_valid = '0;
    bus.in_last  = '0;

    // Test 4: req2 stalls 3 cycles while req3 waits
    bus.in_valid[2] = 1'b1; bus.in_word[16 +: 8] = 8'h11; bus.in_last[2] = 1'b0;
    bus.in_valid[3] = 1'b1; bus.in_word[24 +: 8] = 8'h77; bus.in_last[3] = 1'b1;
    guard = 0;
    while (!bus.in_ready[2] && guard < 50) begin
      step();
      guard++;
    end
    check("t4_grant2", 32'(bus.in_ready), 32'h4);
    step();
    step();
    bus.in_valid[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_r3_blocked", 32'(bus.in_ready[3]), 32'd0);
      check("t4_r2_held",    32'(bus.in_ready[2]), 32'd1);
    end
    bus.in_valid[2] = 1'b1; bus.in_word[16 +: 8] = 8'h22;
    step();
    bus.in_last[2] = 1'b1;
    step();
    bus.in_valid[2] = 1'b0; bus.in_last[2] = 1'b0;
    check("t4_res_valid", 32'(bus.res_valid), 32'd1);
    check("t4_res_count", 32'(bus.res_count), 32'd2);
    check("t4_res_len",   32'(bus.res_len),   32'd4);
    check("t4_res_src",   32'(bus.res_src),   32'd2);
    wq[0] = 8'h77;
    burst(3, 1);
    check("t4b_res_count", 32'(bus.res_count), 32'd0);
    check("t4b_res_len",   32'(bus.res_len),   32'd1);
    check("t4b_res_src",   32'(bus.res_src),   32'd3);
    step();

    // Test 5: result back-pressure for 5 cycles
    bus.res_ready = 1'b0;
    bus.in_valid[1] = 1'b1; bus.in_word[8 +: 8] = 8'h99; bus.in_last[1] = 1'b1;
    wq[0] = 8'h05; wq[1] = 8'h05;
    burst(0, 2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_res_valid", 32'(bus.res_valid), 32'd1);
      check("t5_res_count", 32'(bus.res_count), 32'd1);
      check("t5_res_len",   32'(bus.res_len),   32'd2);
      check("t5_res_src",   32'(bus.res_src),   32'd0);
      check("t5_no_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.res_ready = 1'b1;
    step();
    bus.in_valid[1] = 1'b0; bus.in_last[1] = 1'b0;
    check("t5_res_valid_clr", 32'(bus.res_valid), 32'd0);
    check("t5_idle",          32'(bus.busy),      32'd0);

    // Test 6: CNT_W=4 saturation with 20 identical words
    bus6.in_valid[0] = 1'b1; bus6.in_word[7:0] = 8'h5A; bus6.in_last[0] = 1'b0;
    guard = 0;
    while (!bus6.in_ready[0] && guard < 50) begin
      step();
      guard++;
    end
    check("t6_ready", 32'(bus6.in_ready[0]), 32'd1);
    for (int i = 0; i < 20; i++) begin
      bus6.in_last[0] = (i == 19);
      step();
    end
    bus6.in_valid[0] = 1'b0; bus6.in_last[0] = 1'b0;
    check("t6_res_valid", 32'(bus6.res_valid), 32'd1);
    check("t6_res_count", 32'(bus6.res_count), 32'd15);
    check("t6_res_len",   32'(bus6.res_len),   32'd15);
    check("t6_res_src",   32'(bus6.res_src),   32'd0);
    step();

    // Mid-burst reset aborts without a result
    bus6.in_valid[0] = 1'b1;
    guard = 0;
    while (!bus6.in_ready[0] && guard < 50) begin
      step();
      guard++;
    end
    step(); step(); step();
    reset_n = 1'b0;
    #1;
    check("t6r_in_ready",  32'(bus6.in_ready),  32'd0);
    check("t6r_res_valid", 32'(bus6.res_valid), 32'd0);
    check("t6r_res_count", 32'(bus6.res_count), 32'd0);
    check("t6r_res_len",   32'(bus6.res_len),   32'd0);
    check("t6r_res_src",   32'(bus6.res_src),   32'd0);
    check("t6r_busy",      32'(bus6.busy),      32'd0);
    check("t6r_main_cnt",  32'(bus.res_count),  32'd0);
    bus6.in_valid[0] = 1'b0;
    step();
    reset_n = 1'b1;
    step(); step(); step();
    check("t6r_no_result", 32'(bus6.res_valid), 32'd0);
    check("t6r_idle",      32'(bus6.busy),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
